// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the AES key-schedule engine.
//   - Key-length encoding (AES_128 / AES_256).
//   - Nk (key words) and Nr (rounds) for each key length.
//   - rot_word: cyclic left byte rotation of a schedule word.
//   - xtime: GF(2^8) multiply-by-2 with the AES reduction polynomial.
// -----------------------------------------------------------------------------
package aes_pkg;

  // Key-length encoding as seen on the keylen port.
  localparam logic AES_128 = 1'b0;
  localparam logic AES_256 = 1'b1;

  // Words per cipher key.
  localparam int NK_128 = 4;
  localparam int NK_256 = 8;

  // Rounds per key length.
  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  // Total schedule words for the largest supported key.
  localparam int MAX_WORDS = 4 * (NR_256 + 1);

  // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // xtime: multiply by x in GF(2^8), reducing by 0x1b when the MSB shifts out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// -----------------------------------------------------------------------------
// aes_rk_store
// Round-key register file for the key-schedule engine.
// Holds 4*NUM_RK 32-bit schedule words. One bulk key-load port writes the
// first eight words straight from the cipher key; one word write port stores
// each expanded word. The read side returns four consecutive words as one
// 128-bit round key, gated to zero when the schedule is not valid or the
// requested round is beyond the last round of the active key length.
//
// Ports:
//   clk        in   1    clock
//   load       in   1    write key words 0..7 from load_key
//   load_key   in   256  cipher key, MSB-aligned (word 0 in [255:224])
//   wr_en      in   1    write wr_data to word wr_addr
//   wr_addr    in   6    schedule word index
//   wr_data    in   32   schedule word
//   rd_valid   in   1    schedule complete; enables the read
//   max_round  in   4    highest readable round index (Nr)
//   round      in   4    round-key index to read
//   round_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} or 0
// -----------------------------------------------------------------------------
module aes_rk_store #(
  parameter int NUM_RK = 15
) (
  input  logic         clk,
  input  logic         load,
  input  logic [255:0] load_key,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         rd_valid,
  input  logic [3:0]   max_round,
  input  logic [3:0]   round,
  output logic [127:0] round_key
);

  localparam int NUM_WORDS = 4 * NUM_RK;

  logic [31:0] mem [NUM_WORDS];

  // NOTE: the word array has no reset; stale contents are never observable
  // because the read port is gated by rd_valid, and skipping the reset keeps
  // this a plain register file.
  always_ff @(posedge clk) begin
    if (load) begin
      // For AES-128 words 4..7 receive the zero-extended tail of the key
      // bus; they are overwritten by the expansion before anyone reads them.
      for (int j = 0; j < 8; j++) begin
        mem[j] <= load_key[255 - 32*j -: 32];
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic       in_range;
  logic [5:0] base;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    round_key = '0;
    base      = {round, 2'b00};
    in_range  = rd_valid && (round <= max_round) && (int'(round) < NUM_RK);
    if (in_range) begin
      round_key = {mem[base], mem[base + 6'd1], mem[base + 6'd2], mem[base + 6'd3]};
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Sequential AES key-schedule engine for 128-bit and 256-bit keys. One
// schedule word is produced per clock; SubWord goes through an external
// combinational S-box shared with the datapath (sboxw out, new_sboxw back in
// the same cycle). Round keys are read by index from an internal store.
//
// Ports:
//   clk        in   1    clock, rising edge
//   reset      in   1    synchronous, active-high reset
//   init       in   1    start pulse; samples key and keylen
//   keylen     in   1    0 = AES-128, 1 = AES-256
//   key        in   256  cipher key, MSB-aligned (AES-128 uses [255:128])
//   sboxw      out  32   word to the external S-box (0 when unused)
//   new_sboxw  in   32   S-box result for sboxw
//   round      in   4    round-key index
//   round_key  out  128  round key for index `round`, 0 when not valid
//   ready      out  1    schedule complete and valid
// -----------------------------------------------------------------------------
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int SUPPORT_256 = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);

  localparam int NUM_RK = (SUPPORT_256 != 0) ? 15 : 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [5:0] LAST_128 = 6'(4 * (NR_128 + 1) - 1);
  localparam logic [5:0] LAST_256 = 6'(4 * (NR_256 + 1) - 1);

  logic [1:0]  state;
  logic [5:0]  word_idx;   // index i of the word written on the next edge
  logic [7:0]  rcon;
  logic        key256;     // latched key length
  logic        keylen_eff;

  // Sliding window of the most recent eight schedule words:
  // win[7] = w[i-1]; w[i-Nk] is win[0] for AES-256 and win[4] for AES-128.
  logic [31:0] win [8];

  logic [31:0] prev_word;
  logic [31:0] old_word;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic        rcon_step;
  logic [5:0]  last_idx;
  logic [3:0]  max_round;
  logic        start;

  assign keylen_eff = (SUPPORT_256 != 0) ? keylen : AES_128;
  assign start      = init && !reset;
  assign last_idx   = key256 ? LAST_256 : LAST_128;
  assign max_round  = key256 ? 4'(NR_256) : 4'(NR_128);
  assign ready      = (state == ST_DONE);

  // Word rule; sboxw is held at zero whenever no SubWord is needed.
  always_comb begin
    prev_word = win[7];
    old_word  = key256 ? win[0] : win[4];
    sboxw     = '0;
    temp      = prev_word;
    rcon_step = 1'b0;
    if (state == ST_EXPAND) begin
      if (key256 ? (word_idx[2:0] == 3'd0) : (word_idx[1:0] == 2'd0)) begin
        sboxw     = rot_word(prev_word);
        temp      = new_sboxw ^ {rcon, 24'h0};
        rcon_step = 1'b1;
      end else if (key256 && (word_idx[2:0] == 3'd4)) begin
        sboxw = prev_word;
        temp  = new_sboxw;
      end
    end
    new_word = old_word ^ temp;
  end

  // Control FSM. Reset has priority over init; init in any state restarts.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      rcon     <= '0;
      key256   <= AES_128;
    end else if (init) begin
      state    <= ST_EXPAND;
      word_idx <= keylen_eff ? 6'(NK_256) : 6'(NK_128);
      rcon     <= 8'h01;
      key256   <= keylen_eff;
    end else if (state == ST_EXPAND) begin
      word_idx <= word_idx + 6'd1;
      if (rcon_step) begin
        rcon <= xtime(rcon);
      end
      if (word_idx == last_idx) begin
        state <= ST_DONE;
      end
    end
  end

  // Window: loaded from the key on start, shifted once per expanded word.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int j = 0; j < 8; j++) begin
        // AES-128 places key words 0..3 in win[4..7] (j & 3 maps 4..7 -> 0..3).
        win[j] <= key[255 - 32*(keylen_eff ? j : (j & 3)) -: 32];
      end
    end else if (state == ST_EXPAND) begin
      for (int j = 0; j < 7; j++) begin
        win[j] <= win[j + 1];
      end
      win[7] <= new_word;
    end
  end

  aes_rk_store #(
    .NUM_RK (NUM_RK)
  ) u_store (
    .clk       (clk),
    .load      (start),
    .load_key  (key),
    .wr_en     ((state == ST_EXPAND) && !reset && !init),
    .wr_addr   (word_idx),
    .wr_data   (new_word),
    .rd_valid  (ready),
    .max_round (max_round),
    .round     (round),
    .round_key (round_key)
  );

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
// Directed self-checking bench for aes_key_expand. Provides the external
// S-box from a local table and checks latency, round keys from FIPS-197
// vectors, out-of-range reads, restart and reset behaviour.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [7:0] sbox_tbl [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                      sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};

  aes_key_expand #(
    .SUPPORT_256 (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .keylen    (keylen),
    .key       (key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .round     (round),
    .round_key (round_key),
    .ready     (ready)
  );

  localparam logic [127:0] KEY128_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY256_FIPS =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse init for one edge; returns at the falling edge right after the
  // edge that sampled init.
  task automatic start(input logic kl, input logic [255:0] k);
    @(negedge clk);
    init   = 1'b1;
    keylen = kl;
    key    = k;
    @(negedge clk);
    init   = 1'b0;
  endtask

  // Count rising edges until ready, bounded; called right after start().
  task automatic wait_ready(input int exp_edges, input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_edges));
    check({tag, "_ready"}, 128'(ready), 128'd1);
  endtask

  task automatic read_rk(input logic [3:0] r, input logic [127:0] exp, input string tag);
    round = r;
    #1;
    check(tag, round_key, exp);
  endtask

  initial begin
    reset  = 1'b1;
    init   = 1'b0;
    keylen = 1'b0;
    key    = '0;
    round  = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_ready", 128'(ready), 128'd0);
    check("rst_rk", round_key, 128'd0);
    check("rst_sboxw", 128'(sboxw), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // AES-128, all-zero key.
    start(1'b0, '0);
    wait_ready(40, "z128");
    read_rk(4'd0,  128'h0, "z128_r0");
    read_rk(4'd1,  128'h62636363626363636263636362636363, "z128_r1");
    read_rk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "z128_r10");

    // AES-128, FIPS-197 key; first SubWord input is RotWord(w3).
    start(1'b0, {KEY128_FIPS, 128'h0});
    check("f128_sboxw0", 128'(sboxw), 128'h0000_0000_0000_0000_0000_0000_cf4f_3c09);
    wait_ready(40, "f128");
    read_rk(4'd0,  KEY128_FIPS, "f128_r0");
    read_rk(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "f128_r1");
    read_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "f128_r10");
    for (int r = 11; r < 16; r++) begin
      read_rk(4'(r), 128'h0, $sformatf("f128_r%0d", r));
    end
    check("f128_done_sboxw", 128'(sboxw), 128'd0);
    // keylen change without init has no effect.
    keylen = 1'b1;
    read_rk(4'd14, 128'h0, "f128_kl_r14");
    read_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "f128_kl_r10");

    // AES-256, FIPS-197 A.3 key.
    start(1'b1, KEY256_FIPS);
    check("f256_ready_drop", 128'(ready), 128'd0);
    wait_ready(52, "f256");
    read_rk(4'd0,  KEY256_FIPS[255:128], "f256_r0");
    read_rk(4'd1,  KEY256_FIPS[127:0], "f256_r1");
    read_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "f256_r14");
    read_rk(4'd15, 128'h0, "f256_r15");

    // AES-256, all-zero key: exercises the i mod 8 == 4 SubWord path.
    start(1'b1, '0);
    wait_ready(52, "z256");
    read_rk(4'd1, 128'h0, "z256_r1");
    read_rk(4'd2, 128'h62636363626363636263636362636363, "z256_r2");
    read_rk(4'd3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, "z256_r3");

    // Restart mid-expansion with an AES-128 zero key.
    start(1'b1, KEY256_FIPS);
    repeat (20) @(negedge clk);
    check("rs_mid_ready", 128'(ready), 128'd0);
    start(1'b0, '0);
    check("rs_ready_low", 128'(ready), 128'd0);
    wait_ready(40, "rs");
    read_rk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "rs_r10");
    read_rk(4'd14, 128'h0, "rs_r14");

    // Reset during expansion, asserted together with init: reset wins.
    start(1'b0, {KEY128_FIPS, 128'h0});
    repeat (10) @(negedge clk);
    reset = 1'b1;
    init  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    init  = 1'b0;
    repeat (60) @(negedge clk);
    check("rx_ready", 128'(ready), 128'd0);
    read_rk(4'd0, 128'h0, "rx_r0");
    check("rx_sboxw", 128'(sboxw), 128'd0);
    start(1'b0, {KEY128_FIPS, 128'h0});
    wait_ready(40, "rx2");
    read_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rx2_r10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES key-schedule engine; successor to the fixed AES-128 key mapper.
- Supports 128-bit and 256-bit keys, selected at run time.
- Generates one 32-bit schedule word per cycle, sharing the external S-box word port (sboxw/new_sboxw) with the datapath.
- Round keys are held internally and read by index, not through fixed per-round ports. Sits between the key register and the aes round core.

Parameters:
- SUPPORT_256, 1, 1: AES-128 and AES-256 both available. 0: AES-128 only, keylen ignored, storage limited to 11 round keys.
- NUM_RK, derived (15 if SUPPORT_256 else 11), number of 128-bit round-key slots.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  single-cycle start pulse; samples key and keylen.
- keylen  in  1  0 = AES-128 (Nk=4, Nr=10), 1 = AES-256 (Nk=8, Nr=14).
- key  in  256  cipher key, MSB-aligned; AES-128 uses key[255:128].
- sboxw  out  32  word sent to the external combinational S-box.
- new_sboxw  in  32  S-box result for sboxw, valid in the same cycle.
- round  in  4  round-key index to read.
- round_key  out  128  key for index `round`; combinational read.
- ready  out  1  high when the schedule is complete and valid.

Behaviour:
- Reset (reset=1 at a rising edge):
  - FSM goes to IDLE; ready=0; word counter and rcon are cleared.
  - round_key reads 0 while ready=0. sboxw is 0 in IDLE.
  - Storage contents are not cleared.
- FSM has three states: IDLE, EXPAND, DONE.
  - IDLE: on init, load w[0..Nk-1] from key, set i=Nk, rcon=0x01, latch keylen, go to EXPAND.
  - EXPAND: each edge writes w[i] and increments i. When i = 4*(Nr+1)-1 is written, go to DONE and set ready=1 on that same edge.
  - DONE: hold; ready=1 until the next init or reset.
- Word rule (temp = w[i-1]):
  - If i mod Nk == 0: sboxw = RotWord(temp) (byte rotate left by 8); temp' = new_sboxw ^ {rcon,24'h0}.
  - Rcon update: rcon <= xtime(rcon), where xtime reduces by 0x1b when the MSB is set.
  - Else if Nk=8 and i mod 8 == 4: sboxw = temp; temp' = new_sboxw.
  - Else: temp' = temp, and sboxw = 0 (held 0 to save power).
  - In all cases w[i] = w[i-Nk] ^ temp'.
- Latency from the edge that samples init to the edge that sets ready:
  - AES-128: 40 edges (w4..w43).
  - AES-256: 52 edges (w8..w59).
- Storage layout: round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] is in bits [127:96].
- Boundary conditions:
  - init in EXPAND or DONE: restart. ready=0 from the next edge; the old schedule is discarded; new key and keylen are taken.
  - init and reset in the same cycle: reset wins.
  - round > Nr of the latched keylen (including 11..15 for AES-128): round_key = 0.
  - keylen changes without init: no effect, because keylen is latched.
  - SUPPORT_256=0: keylen is treated as 0.
  - reset during EXPAND: go to IDLE, ready stays 0, no partial schedule is visible.

Decomposition:
- Shared package aes_pkg holds:
  - Nk/Nr constants per key length.
  - Keylen encoding constants (AES_128=1'b0, AES_256=1'b1).
  - RotWord and xtime functions.
- One sub-module, aes_rk_store: 60x32 word register file with one write port and a 4-word-wide combinational read. It also performs the round-range check and zero gating.
- The S-box stays external and shared; it is not instantiated in this block.

Test Plan:
- AES-128 all-zero key, init:
  - ready exactly 40 edges after init.
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
  - round 0 = the key.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round 11..15 read 0.
- AES-256 key 603deb10...0914dff4 (FIPS-197 A.3):
  - ready after 52 edges.
  - round 14 = fe4890d1e6188d0b046df344706c631e.
- AES-256 all-zero key:
  - round 2 = 62636363 repeated 4x.
  - round 3 = aafbfbfb repeated 4x (checks the i mod 8 == 4 SubWord path).
- Restart and reset:
  - init for AES-256; after 20 edges, pulse init with AES-128 zero key.
  - ready drops, then rises 40 edges after the second init, and round 10 matches scenario 1.
  - Separately, reset during EXPAND: ready=0 and round_key=0 until a new init completes.
